// File: rtl/diff_mac_sequencer.sv
// diff_mac_sequencer: computes y[n] = C*(x[n] + 2x[n-1] - 2x[n-3] - x[n-4])
// in signed fixed point using one shared multiplier, one tap per cycle.
// Samples come in and results go out over valid/ready handshakes.
// Only one sample is processed at a time.
module diff_mac_sequencer #(
   parameter int DATA_W = 32,
   parameter int FRAC_W = 22,
   parameter logic [DATA_W-1:0] COEF_RESET = 32'h000CD014
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              coef_wr,
   input  logic [DATA_W-1:0] coef_data,
   input  logic              flush,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      OUT
   } state_t;

   state_t state;
   state_t next_state;

   logic [1:0]        k;
   logic [DATA_W-1:0] h0, h1, h2, h3, h4;
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] coef;

   logic                       accept;
   logic                       coef_load;
   logic                       hist_clear;
   logic [DATA_W-1:0]          operand;
   logic signed [2*DATA_W-1:0] op_ext;
   logic signed [2*DATA_W-1:0] coef_ext;
   logic signed [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]          z;
   logic [DATA_W-1:0]          contrib;
   logic [DATA_W-1:0]          acc_next;

   // State register; everything else hangs off the decoded next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode; flush in IDLE blocks both accept and coefficient load.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      coef_load  = 1'b0;
      hist_clear = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            in_ready   = ~flush;
            hist_clear = flush;
            accept     = in_valid & ~flush;
            coef_load  = coef_wr & ~flush;
            if (accept) begin
               next_state = MAC;
            end
         end
         MAC: begin
            if (k == 2'd3) begin
               next_state = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Tap selection, full-precision product and signed tap weighting (+1, +2, -2, -1).
   always_comb begin
      operand = h0;
      case (k)
         2'd0:    operand = h0;
         2'd1:    operand = h1;
         2'd2:    operand = h3;
         default: operand = h4;
      endcase
      op_ext   = {{DATA_W{operand[DATA_W-1]}}, operand};
      coef_ext = {{DATA_W{coef[DATA_W-1]}}, coef};
      prod     = op_ext * coef_ext;
      z        = DATA_W'(prod >>> FRAC_W);
      contrib  = z;
      case (k)
         2'd0:    contrib = z;
         2'd1:    contrib = z << 1;
         2'd2:    contrib = -(z << 1);
         default: contrib = -z;
      endcase
      acc_next = acc + contrib;
   end

   // Datapath: history shift on accept, coefficient load, accumulation and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         h0        <= '0;
         h1        <= '0;
         h2        <= '0;
         h3        <= '0;
         h4        <= '0;
         acc       <= '0;
         k         <= '0;
         coef      <= COEF_RESET;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (hist_clear) begin
            h0 <= '0;
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
            h4 <= '0;
         end else if (accept) begin
            h4 <= h3;
            h3 <= h2;
            h2 <= h1;
            h1 <= h0;
            h0 <= in_data;
         end
         if (coef_load) begin
            coef <= coef_data;
         end
         if (accept) begin
            acc <= '0;
            k   <= '0;
         end else if (state == MAC) begin
            acc <= acc_next;
            k   <= k + 2'd1;
            if (k == 2'd3) begin
               out_data  <= acc_next;
               out_valid <= 1'b1;
            end
         end
         if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_diff_mac_sequencer.sv
// tb_diff_mac_sequencer: directed scenarios with hand-computed results.
module tb_diff_mac_sequencer;

   localparam logic [31:0] ONE = 32'h00400000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        coef_wr;
   logic [31:0] coef_data;
   logic        flush;
   logic        busy;

   int errors = 0;
   int checks = 0;

   diff_mac_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .coef_wr   (coef_wr),
      .coef_data (coef_data),
      .flush     (flush),
      .busy      (busy)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      coef_wr   = 1'b0;
      coef_data = '0;
      flush     = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic write_coef(input logic [31:0] c);
      coef_wr   = 1'b1;
      coef_data = c;
      step();
      coef_wr = 1'b0;
   endtask

   // Presents one sample and returns just after the edge that accepts it.
   task automatic accept_sample(input logic [31:0] d);
      int n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
      end
      in_data  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Waits for out_valid, counting edges since the accept, then takes the result.
   task automatic collect_result(input int start, output logic [31:0] res, output int lat);
      lat = start;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL result_timeout: out_valid=%b required 1", out_valid);
         lat = -1;
      end
      res       = out_data;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      coef_wr   = 1'b0;
      coef_data = '0;
      flush     = 1'b0;
      step();
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid);
      end
      checks++;
      if (out_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_out_data: got %h required 00000000", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %b required 0", busy);
      end
      rst = 1'b0;
   endtask

   // Expects coef = 1.0 and a zero history on entry.
   task automatic test_impulse(input string tag);
      logic [31:0] stim [6] = '{ONE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [31:0] expv [6] = '{32'h00400000, 32'h00800000, 32'h00000000,
                                32'hFF800000, 32'hFFC00000, 32'h00000000};
      logic [31:0] res;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         accept_sample(stim[i]);
         collect_result(0, res, lat);
         checks++;
         if (res !== expv[i]) begin
            errors++;
            $display("[TB] FAIL %s_data[%0d]: got %h required %h", tag, i, res, expv[i]);
         end
         checks++;
         if (lat !== 4) begin
            errors++;
            $display("[TB] FAIL %s_latency[%0d]: got %0d required 4", tag, i, lat);
         end
      end
   endtask

   task automatic test_step();
      logic [31:0] expv [7] = '{32'h00400000, 32'h00C00000, 32'h00C00000, 32'h00400000,
                                32'h0, 32'h0, 32'h0};
      logic [31:0] res;
      int          lat;
      do_reset();
      write_coef(ONE);
      for (int i = 0; i < 7; i++) begin
         accept_sample(ONE);
         collect_result(0, res, lat);
         checks++;
         if (res !== expv[i]) begin
            errors++;
            $display("[TB] FAIL step_data[%0d]: got %h required %h", i, res, expv[i]);
         end
      end
   endtask

   task automatic test_default_coef();
      logic [31:0] res;
      int          lat;
      do_reset();
      accept_sample(ONE);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h000CD014) begin
         errors++;
         $display("[TB] FAIL default_coef_0: got %h required 000cd014", res);
      end
      accept_sample(32'h0);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h0019A028) begin
         errors++;
         $display("[TB] FAIL default_coef_1: got %h required 0019a028", res);
      end
   endtask

   task automatic test_wrap_trunc();
      logic [31:0] res;
      int          lat;
      do_reset();
      write_coef(ONE);
      accept_sample(32'h7FFFFFFF);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h7FFFFFFF) begin
         errors++;
         $display("[TB] FAIL wrap_0: got %h required 7fffffff", res);
      end
      accept_sample(32'h7FFFFFFF);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h7FFFFFFD) begin
         errors++;
         $display("[TB] FAIL wrap_1: got %h required 7ffffffd", res);
      end
      do_reset();
      write_coef(32'hFFE00000);
      accept_sample(32'h00000003);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'hFFFFFFFE) begin
         errors++;
         $display("[TB] FAIL truncate_neg: got %h required fffffffe", res);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      int          lat;
      int          n = 0;
      do_reset();
      write_coef(ONE);
      accept_sample(ONE);
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      in_data  = 32'h0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== ONE) begin
            errors++;
            $display("[TB] FAIL bp_hold[%0d]: got valid=%b data=%h required valid=1 data=%h",
                     i, out_valid, out_data, ONE);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_release: got valid=%b in_ready=%b required valid=0 in_ready=1",
                  out_valid, in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_next_accept: got busy=%b required 1", busy);
      end
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h00800000 || lat !== 4) begin
         errors++;
         $display("[TB] FAIL bp_next_result: got %h lat=%0d required 00800000 lat=4", res, lat);
      end
   endtask

   task automatic test_coef_write();
      logic [31:0] res;
      int          lat;
      do_reset();
      write_coef(ONE);
      accept_sample(ONE);
      coef_wr   = 1'b1;
      coef_data = 32'h00800000;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL coef_busy: got %b required 1", busy);
      end
      step();
      coef_wr = 1'b0;
      collect_result(1, res, lat);
      checks++;
      if (res !== ONE || lat !== 4) begin
         errors++;
         $display("[TB] FAIL coef_ignored_cur: got %h lat=%0d required 00400000 lat=4", res, lat);
      end
      accept_sample(32'h0);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h00800000) begin
         errors++;
         $display("[TB] FAIL coef_ignored_next: got %h required 00800000", res);
      end
      accept_sample(32'h0);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'h0) begin
         errors++;
         $display("[TB] FAIL coef_mid: got %h required 00000000", res);
      end
      write_coef(32'h00800000);
      accept_sample(32'h0);
      collect_result(0, res, lat);
      checks++;
      if (res !== 32'hFF000000) begin
         errors++;
         $display("[TB] FAIL coef_idle_write: got %h required ff000000", res);
      end
   endtask

   task automatic test_reset_mid_mac();
      logic [31:0] res;
      int          lat;
      do_reset();
      write_coef(ONE);
      accept_sample(ONE);
      collect_result(0, res, lat);
      accept_sample(ONE);
      step();
      step();
      rst = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midmac_reset: got valid=%b busy=%b in_ready=%b data=%h required 0 0 1 00000000",
                  out_valid, busy, in_ready, out_data);
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midmac_quiet[%0d]: got %b required 0", i, out_valid);
         end
         step();
      end
      write_coef(ONE);
      test_impulse("after_reset");
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          lat;
      do_reset();
      write_coef(ONE);
      accept_sample(ONE);
      collect_result(0, res, lat);
      accept_sample(ONE);
      collect_result(0, res, lat);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h12345678;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_in_ready: got %b required 0", in_ready);
      end
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_no_accept: got busy=%b valid=%b required 0 0", busy, out_valid);
      end
      test_impulse("after_flush");
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      test_reset();
      do_reset();
      write_coef(ONE);
      test_impulse("impulse");
      test_step();
      test_default_coef();
      test_wrap_trunc();
      test_backpressure();
      test_coef_write();
      test_reset_mid_mac();
      test_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
